instr_byte_fetch: RTL and testbench

//  Upstream feeder for the instruction register. Owns the program counter (PC).

---
 rtl/instr_byte_fetch.sv | 130 +++++++++++++
 tb/tb_instr_byte_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_byte_fetch.sv
// Program-counter owner that reads a byte-wide synchronous instruction memory
// and streams each 32-bit instruction to the consumer as 4 bytes, LSB first.
module instr_byte_fetch #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_byte_out,
  output logic              o_byte_valid,
  input  logic              i_byte_ready,
  output logic [1:0]        o_byte_idx,
  output logic              o_instr_done,
  output logic              o_flush,
  input  logic              i_redirect_en,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_pc,
  output logic [1:0]        o_state
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_RESET   = RESET_PC & ALIGN_MASK;
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CAPT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_byte_idx;
  logic [7:0]        r_byte_out;
  logic              r_byte_valid;

  logic              w_mem_rd;
  logic              w_transfer;
  logic              w_last_byte;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_redirect_pc;

  // Handshake: a byte moves in every cycle where o_byte_valid and i_byte_ready
  // are both high; once raised, o_byte_valid and o_byte_out hold until that
  // transfer or a redirect. A redirect overrides everything except reset.
  always_comb begin
    w_next_state = r_state;
    w_mem_rd     = 1'b0;
    w_transfer   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) w_next_state = S_REQ;
      end
      S_REQ: begin
        w_mem_rd     = 1'b1;
        w_next_state = S_CAPT;
      end
      S_CAPT: begin
        w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (i_byte_ready) begin
          w_transfer   = 1'b1;
          w_next_state = i_run ? S_REQ : S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // Any read already in flight is dropped because CAPT is bypassed.
    if (i_redirect_en) begin
      w_mem_rd     = 1'b0;
      w_next_state = i_run ? S_REQ : S_IDLE;
    end
  end

  assign w_last_byte   = (r_byte_idx == 2'd3);
  assign w_pc_inc      = r_pc + PC_STEP;
  assign w_redirect_pc = i_redirect_pc & ALIGN_MASK;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_pc         <= PC_RESET;
      r_byte_idx   <= 2'd0;
      r_byte_out   <= 8'd0;
      r_byte_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (i_redirect_en) begin
        r_pc         <= w_redirect_pc;
        r_byte_idx   <= 2'd0;
        r_byte_valid <= 1'b0;
      end else begin
        if (r_state == S_CAPT) begin
          r_byte_out   <= i_mem_data;
          r_byte_valid <= 1'b1;
        end
        if (w_transfer) begin
          r_byte_valid <= 1'b0;
          if (w_last_byte) begin
            r_byte_idx <= 2'd0;
            r_pc       <= w_pc_inc;
          end else begin
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
      end
    end
  end

  assign o_mem_rd     = w_mem_rd;
  assign o_mem_addr   = (r_state == S_REQ) ? {r_pc[ADDR_W-1:2], r_byte_idx} : '0;
  assign o_byte_out   = r_byte_out;
  assign o_byte_valid = r_byte_valid;
  assign o_byte_idx   = r_byte_idx;
  // A redirect coinciding with the byte-3 transfer still completes the instruction.
  assign o_instr_done = w_transfer & w_last_byte;
  assign o_flush      = i_redirect_en;
  assign o_pc         = r_pc;
  assign o_state      = r_state;

endmodule

// File: tb/tb_instr_byte_fetch.sv
// Bench for instr_byte_fetch: directed scenarios followed by random run/ready/redirect
// traffic, checked every cycle against a transaction-level fetch model.
module tb_instr_byte_fetch;

  localparam logic [15:0] RST_PC  = 16'hFFFC;
  localparam logic [1:0]  ST_IDLE = 2'd0;

  logic        clk = 1'b0;
  logic        i_rst, i_run, i_byte_ready, i_redirect_en;
  logic [15:0] i_redirect_pc;
  logic [7:0]  i_mem_data;
  logic        o_mem_rd, o_byte_valid, o_instr_done, o_flush;
  logic [15:0] o_mem_addr, o_pc;
  logic [7:0]  o_byte_out;
  logic [1:0]  o_byte_idx, o_state;

  logic [7:0]  mem_arr [0:65535];

  int          n_checks = 0;
  int          n_bad    = 0;
  int          n_hs     = 0;

  // reference model: address of the next byte the consumer should receive
  logic [15:0] m_pc;
  logic [1:0]  m_idx;
  logic [7:0]  exp_q [$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte;

  instr_byte_fetch #(.ADDR_W(16), .RESET_PC(RST_PC)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_run         (i_run),
    .o_mem_rd      (o_mem_rd),
    .o_mem_addr    (o_mem_addr),
    .i_mem_data    (i_mem_data),
    .o_byte_out    (o_byte_out),
    .o_byte_valid  (o_byte_valid),
    .i_byte_ready  (i_byte_ready),
    .o_byte_idx    (o_byte_idx),
    .o_instr_done  (o_instr_done),
    .o_flush       (o_flush),
    .i_redirect_en (i_redirect_en),
    .i_redirect_pc (i_redirect_pc),
    .o_pc          (o_pc),
    .o_state       (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous byte memory: data one cycle after the read strobe, garbage otherwise
  always @(posedge clk) begin
    if (o_mem_rd) i_mem_data <= mem_arr[o_mem_addr];
    else          i_mem_data <= 8'($urandom);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_idx(input logic [1:0] idx, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(o_mem_rd && o_mem_addr[1:0] == idx) && n < 200);
    check_val(tag, 32'(o_mem_rd && o_mem_addr[1:0] == idx), 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_byte_valid && n < 200);
    check_val(tag, 32'(o_byte_valid), 1);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic        hs;
    logic [15:0] a;
    logic [7:0]  e;
    if (i_rst) begin
      m_pc       = RST_PC;
      m_idx      = 2'd0;
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      hs = o_byte_valid && i_byte_ready;
      check_val("pc", o_pc, m_pc);
      check_val("flush", o_flush, i_redirect_en);
      check_val("instr_done", o_instr_done, 32'(hs && m_idx == 2'd3));
      if (o_byte_valid) check_val("rd_while_valid", o_mem_rd, 0);
      if (prev_stall) begin
        check_val("hold_valid", o_byte_valid, 1);
        check_val("hold_byte", o_byte_out, prev_byte);
      end
      if (o_mem_rd) begin
        a = {m_pc[15:2], m_idx};
        check_val("mem_addr", o_mem_addr, a);
        exp_q.push_back(mem_arr[a]);
      end
      if (hs) begin
        n_hs++;
        check_val("byte_idx", o_byte_idx, m_idx);
        check_val("reads_outstanding", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("byte_out", o_byte_out, e);
        end
        if (m_idx == 2'd3) begin
          m_idx = 2'd0;
          m_pc  = m_pc + 16'd4;
        end else begin
          m_idx = m_idx + 2'd1;
        end
      end
      prev_stall = o_byte_valid && !i_byte_ready && !i_redirect_en;
      prev_byte  = o_byte_out;
      if (i_redirect_en) begin
        m_pc  = i_redirect_pc & 16'hFFFC;
        m_idx = 2'd0;
        exp_q.delete();
      end
    end
  end

  initial begin
    int          first_rd;
    int          done_c [$];
    logic [7:0]  got [$];
    logic [15:0] a1, a13;
    logic [7:0]  exp_bytes [0:7];

    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);
    mem_arr[16'hFFFC] = 8'hA1; mem_arr[16'hFFFD] = 8'hB2;
    mem_arr[16'hFFFE] = 8'hC3; mem_arr[16'hFFFF] = 8'hD4;
    for (int i = 0; i < 8; i += 4) begin
      mem_arr[i] = 8'h78; mem_arr[i+1] = 8'h56; mem_arr[i+2] = 8'h34; mem_arr[i+3] = 8'h12;
    end
    exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hB2; exp_bytes[2] = 8'hC3; exp_bytes[3] = 8'hD4;
    exp_bytes[4] = 8'h78; exp_bytes[5] = 8'h56; exp_bytes[6] = 8'h34; exp_bytes[7] = 8'h12;

    i_rst = 1'b1; i_run = 1'b0; i_byte_ready = 1'b1;
    i_redirect_en = 1'b0; i_redirect_pc = 16'h0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;

    // reset state
    @(negedge clk);
    check_val("rst_mem_rd", o_mem_rd, 0);
    check_val("rst_mem_addr", o_mem_addr, 0);
    check_val("rst_byte_out", o_byte_out, 0);
    check_val("rst_byte_valid", o_byte_valid, 0);
    check_val("rst_byte_idx", o_byte_idx, 0);
    check_val("rst_pc", o_pc, RST_PC);
    check_val("rst_state", o_state, ST_IDLE);

    // two instructions from 0xFFFC: wrap to 0x0000, 12 cycles each
    step();
    i_run = 1'b1;
    first_rd = -1; a1 = '0; a13 = '0;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      if (o_mem_rd && first_rd < 0) first_rd = c;
      if (c == 1)  a1  = o_mem_addr;
      if (c == 13) a13 = o_mem_addr;
      if (o_byte_valid && i_byte_ready) got.push_back(o_byte_out);
      if (o_instr_done) done_c.push_back(c);
    end
    @(negedge clk);
    check_val("first_rd_cycle", first_rd, 1);
    check_val("first_addr", a1, 16'hFFFC);
    check_val("wrap_addr", a13, 16'h0000);
    check_val("done_count", done_c.size(), 2);
    if (done_c.size() == 2) begin
      check_val("done_cycle_0", done_c[0], 12);
      check_val("done_cycle_1", done_c[1], 24);
    end
    check_val("byte_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check_val("stream_byte", got[i], exp_bytes[i]);
    check_val("pc_after_two", o_pc, 16'h0004);

    // stall on byte 1 of the instruction at 0x0004
    wait_rd_idx(2'd1, "reach_byte1");
    step();
    i_byte_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("stall_valid", o_byte_valid, 1);
      check_val("stall_byte", o_byte_out, 8'h56);
      check_val("stall_idx", o_byte_idx, 1);
      check_val("stall_no_rd", o_mem_rd, 0);
    end
    step();
    i_byte_ready = 1'b1;
    @(negedge clk);
    check_val("resume_valid", o_byte_valid, 1);
    check_val("resume_byte", o_byte_out, 8'h56);

    // redirect to 0x0103 while byte 2 is in flight
    wait_rd_idx(2'd2, "reach_byte2");
    step();
    i_redirect_en = 1'b1; i_redirect_pc = 16'h0103;
    @(negedge clk);
    check_val("redir_flush", o_flush, 1);
    check_val("redir_no_rd", o_mem_rd, 0);
    step();
    i_redirect_en = 1'b0;
    @(negedge clk);
    check_val("redir_pc", o_pc, 16'h0100);
    check_val("redir_idx", o_byte_idx, 0);
    check_val("redir_valid", o_byte_valid, 0);
    check_val("redir_flush_gone", o_flush, 0);
    check_val("redir_rd", o_mem_rd, 1);
    check_val("redir_addr", o_mem_addr, 16'h0100);

    // drop run while byte 1 is pending, then resume at byte 2
    wait_rd_idx(2'd1, "reach_byte1_b");
    step();
    i_run = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("idle_state", o_state, ST_IDLE);
      check_val("idle_idx", o_byte_idx, 2);
      check_val("idle_no_rd", o_mem_rd, 0);
      check_val("idle_valid", o_byte_valid, 0);
    end
    step();
    i_run = 1'b1;
    @(negedge clk);
    check_val("resume_no_rd_yet", o_mem_rd, 0);
    @(negedge clk);
    check_val("resume_rd", o_mem_rd, 1);
    check_val("resume_addr", o_mem_addr, 16'h0102);

    // reset in HOLD with a redirect requested in the same cycle
    step();
    i_byte_ready = 1'b0;
    wait_valid("reach_hold");
    step();
    i_rst = 1'b1; i_redirect_en = 1'b1; i_redirect_pc = 16'h1234;
    step();
    i_rst = 1'b0; i_redirect_en = 1'b0; i_run = 1'b0; i_byte_ready = 1'b1;
    @(negedge clk);
    check_val("rst2_pc", o_pc, RST_PC);
    check_val("rst2_mem_rd", o_mem_rd, 0);
    check_val("rst2_mem_addr", o_mem_addr, 0);
    check_val("rst2_byte_out", o_byte_out, 0);
    check_val("rst2_valid", o_byte_valid, 0);
    check_val("rst2_idx", o_byte_idx, 0);
    check_val("rst2_done", o_instr_done, 0);
    check_val("rst2_flush", o_flush, 0);

    // random traffic against the model
    n_hs = 0;
    for (int k = 0; k < 4000; k++) begin
      step();
      i_run         = ($urandom_range(0, 9) != 0);
      i_byte_ready  = ($urandom_range(0, 3) != 0);
      i_redirect_en = ($urandom_range(0, 39) == 0);
      i_redirect_pc = 16'($urandom);
    end
    step();
    i_redirect_en = 1'b0; i_run = 1'b0; i_byte_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_val("progress", 32'(n_hs > 200), 1);
    check_val("drained_idle", o_state, ST_IDLE);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
